lsu_unit: RTL and testbench

Load/store unit sitting on the receiver end of `lsu_issue_if`, downstream of the issue stage. Accepts one load or store uop at a time and computes the effective address. Drives a single-outstanding request/grant/response data-memory port, formats load data, and returns a one-cycle write-back pulse to the retire/ARF path. Holds the issuer via `s_stall_from_lsu` while an access is in flight.

---
 rtl/riscv_uop_pkg.sv | 26 ++
 rtl/lsu_issue_if.sv | 22 ++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu_unit.sv | 155 +++++++++++++++
 tb/tb_lsu_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_uop_pkg.sv
// Shared uop encoding plus load/store unit types: FSM states, access-size codes and opcodes.
package riscv_uop_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3[1:0] encodes access size; funct3[2] marks unsigned loads
  localparam logic [2:0] LSU_SIZE_B = 3'b000;
  localparam logic [2:0] LSU_SIZE_H = 3'b001;
  localparam logic [2:0] LSU_SIZE_W = 3'b010;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm;
  } uop_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_RESP,
    LSU_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_issue_if.sv
// Issue-stage to load/store unit handshake: uop, operands and the stall back-pressure.
interface lsu_issue_if;
  import riscv_uop_pkg::*;

  logic        m_valid;
  uop_t        m_uop;
  logic [31:0] m_pc;
  logic [31:0] m_addr_base;
  logic [31:0] m_store_data;
  logic        s_stall_from_lsu;

  modport sender (
    output m_valid, m_uop, m_pc, m_addr_base, m_store_data,
    input  s_stall_from_lsu
  );

  modport receiver (
    input  m_valid, m_uop, m_pc, m_addr_base, m_store_data,
    output s_stall_from_lsu
  );

endinterface

// File: rtl/lsu_load_align.sv
// Load data formatting: lane select by address offset, then sign or zero extension.
module lsu_load_align
  import riscv_uop_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halfwords honour only offset[1]; words always come from lane 0
  assign lane_b = rdata[{offset, 3'b000} +: 8];
  assign lane_h = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    result = rdata;
    case (funct3[1:0])
      LSU_SIZE_B[1:0]: result = {{24{lane_b[7] & ~funct3[2]}}, lane_b};
      LSU_SIZE_H[1:0]: result = {{16{lane_h[15] & ~funct3[2]}}, lane_h};
      default:         result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit: EA generation, dmem req/gnt/rvalid port, load write-back.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_unit
  import riscv_uop_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  lsu_issue_if.receiver        lsu_if,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [31:0]          o_dmem_addr,
  output logic [3:0]           o_dmem_be,
  output logic [31:0]          o_dmem_wdata,
  input  logic                 i_dmem_gnt,
  input  logic                 i_dmem_rvalid,
  input  logic [31:0]          i_dmem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                 o_misaligned,
  output logic [31:0]          o_misaligned_addr,
`endif
  output logic                 o_wb_en,
  output logic [4:0]           o_wb_rd,
  output logic [31:0]          o_wb_data
);

  lsu_state_e  state_q, state_d;
  logic        is_load, is_store, accept, mis_in, stall;
  logic [31:0] ea_in, wdata_in, load_res;
  logic [3:0]  be_in;
  logic [31:0] ea_q, wdata_q, wb_data_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q, kill_q, mis_q;

  assign is_load  = lsu_if.m_uop.opcode == OPC_LOAD;
  assign is_store = lsu_if.m_uop.opcode == OPC_STORE;
  assign ea_in    = lsu_if.m_addr_base + lsu_if.m_uop.imm;
  assign accept   = (state_q == LSU_IDLE) && lsu_if.m_valid && !i_flush && (is_load || is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (lsu_if.m_uop.funct3[1:0])
      LSU_SIZE_B[1:0]: mis_in = 1'b0;
      LSU_SIZE_H[1:0]: mis_in = ea_in[0];
      default:         mis_in = ea_in[1:0] != 2'b00;
    endcase
  end
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = lsu_if.m_store_data;
    case (lsu_if.m_uop.funct3[1:0])
      LSU_SIZE_B[1:0]: begin
        be_in    = 4'b0001 << ea_in[1:0];
        wdata_in = {4{lsu_if.m_store_data[7:0]}};
      end
      LSU_SIZE_H[1:0]: begin
        be_in    = 4'b0011 << {ea_in[1], 1'b0};
        wdata_in = {2{lsu_if.m_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    o_dmem_req = 1'b0;
    o_wb_en    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        stall = accept;
        if (accept) state_d = mis_in ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        stall      = 1'b1;
        o_dmem_req = 1'b1;
        // A grant commits the access even if a flush arrives in the same cycle
        if (i_dmem_gnt)   state_d = we_q ? LSU_DONE : LSU_WAIT_RESP;
        else if (i_flush) state_d = LSU_IDLE;
      end
      LSU_WAIT_RESP: begin
        stall = 1'b1;
        if (i_dmem_rvalid) state_d = LSU_DONE;
      end
      LSU_DONE: begin
        o_wb_en = !we_q && !kill_q && !mis_q && (rd_q != 5'd0) && !i_flush;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  assign lsu_if.s_stall_from_lsu = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q      <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      mis_q     <= 1'b0;
      kill_q    <= 1'b0;
      wb_data_q <= '0;
    end else begin
      if (accept) begin
        ea_q    <= ea_in;
        f3_q    <= lsu_if.m_uop.funct3;
        rd_q    <= lsu_if.m_uop.rd;
        we_q    <= is_store;
        be_q    <= be_in;
        wdata_q <= wdata_in;
        mis_q   <= mis_in;
        kill_q  <= 1'b0;
      end
      if (state_q == LSU_REQ && i_dmem_gnt && i_flush) kill_q <= 1'b1;
      if (state_q == LSU_WAIT_RESP) begin
        if (i_flush)       kill_q    <= 1'b1;
        if (i_dmem_rvalid) wb_data_q <= load_res;
      end
    end
  end

  lsu_load_align u_align (
    .rdata  (i_dmem_rdata),
    .offset (ea_q[1:0]),
    .funct3 (f3_q),
    .result (load_res)
  );

  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {ea_q[31:2], 2'b00};
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_wb_rd      = rd_q;
  assign o_wb_data    = wb_data_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misaligned      = (state_q == LSU_DONE) && mis_q;
  assign o_misaligned_addr = ea_q;
`endif

endmodule

// File: tb/tb_lsu_unit.sv
// Directed and randomized bench for lsu_unit against an arithmetic reference model.
module tb_lsu_unit;
  import riscv_uop_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
  logic [31:0] misaligned_addr;
`endif

  int          vectors;
  int          miscompares;
  logic [31:0] last_wb;

  lsu_issue_if issue_if ();

  lsu_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (i_flush),
    .lsu_if        (issue_if),
    .o_dmem_req    (dmem_req),
    .o_dmem_we     (dmem_we),
    .o_dmem_addr   (dmem_addr),
    .o_dmem_be     (dmem_be),
    .o_dmem_wdata  (dmem_wdata),
    .i_dmem_gnt    (dmem_gnt),
    .i_dmem_rvalid (dmem_rvalid),
    .i_dmem_rdata  (dmem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .o_misaligned      (misaligned),
    .o_misaligned_addr (misaligned_addr),
`endif
    .o_wb_en       (wb_en),
    .o_wb_rd       (wb_rd),
    .o_wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes, byte lane, enables, store image, load result
  function automatic int nbytes(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic int lane_of(input int f3, input logic [31:0] ea);
    int n;
    n = nbytes(f3);
    return (int'(ea % 4) / n) * n;
  endfunction

  function automatic logic [31:0] model_be(input int f3, input logic [31:0] ea);
    return 32'(((1 << nbytes(f3)) - 1) << lane_of(f3, ea));
  endfunction

  function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] sd);
    longint mask, d, w;
    int n;
    n = nbytes(f3);
    mask = (64'd1 << (8 * n)) - 1;
    d = longint'(sd) & mask;
    w = 0;
    for (int k = 0; k < 4 / n; k++) w = w | (d << (8 * n * k));
    return w[31:0];
  endfunction

  function automatic logic [31:0] model_load(input int f3, input logic [31:0] ea, input logic [31:0] rd);
    longint mask, v;
    int n;
    n = nbytes(f3);
    mask = (64'd1 << (8 * n)) - 1;
    v = (longint'(rd) >> (8 * lane_of(f3, ea))) & mask;
    if (f3 < 4 && n < 4 && v > (mask >> 1)) v = v - (mask + 1);
    return v[31:0];
  endfunction

  task automatic set_uop(input logic [6:0] opc, input int f3, input logic [4:0] rd,
                         input logic [31:0] base, input logic [31:0] imm, input logic [31:0] sd);
    issue_if.m_valid           = 1'b1;
    issue_if.m_uop.opcode      = opc;
    issue_if.m_uop.funct3      = f3[2:0];
    issue_if.m_uop.rd          = rd;
    issue_if.m_uop.imm         = imm;
    issue_if.m_addr_base       = base;
    issue_if.m_store_data      = sd;
    issue_if.m_pc              = $urandom;
  endtask

  // fl: 0 none, 1 flush with gnt, 2 flush in WAIT_RESP, 3 flush in REQ before gnt, 4 flush in DONE
  task automatic run_op(input bit ld, input int f3, input logic [4:0] rd, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] sd, input int gd, input int rvd,
                        input logic [31:0] rdat, input int fl);
    logic [31:0] ea;
    bit exp_wb;
    ea = base + imm;
    set_uop(ld ? OPC_LOAD : OPC_STORE, f3, rd, base, imm, sd);
    #1;
    chk("stall_on_accept", issue_if.s_stall_from_lsu, 1);
    tick();
    issue_if.m_valid = 1'b0;
    for (int i = 0; i <= gd; i++) begin
      if (i == gd && fl == 3) begin
        i_flush = 1'b1;
        #1;
        chk("req_before_drop", dmem_req, 1);
        tick();
        i_flush = 1'b0;
        chk("req_after_drop", dmem_req, 0);
        chk("stall_after_drop", issue_if.s_stall_from_lsu, 0);
        return;
      end
      if (i == gd) begin
        dmem_gnt = 1'b1;
        if (fl == 1) i_flush = 1'b1;
      end
      #1;
      chk("req", dmem_req, 1);
      chk("addr", dmem_addr, ea - (ea % 4));
      chk("be", {28'd0, dmem_be}, model_be(f3, ea));
      chk("we", dmem_we, !ld);
      if (!ld) chk("wdata", dmem_wdata, model_wdata(f3, sd));
      chk("stall_req", issue_if.s_stall_from_lsu, 1);
      tick();
      dmem_gnt = 1'b0;
      i_flush  = 1'b0;
    end
    if (ld) begin
      for (int i = 0; i <= rvd; i++) begin
        if (i == 0 && fl == 2) i_flush = 1'b1;
        if (i == rvd) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rdat;
        end
        #1;
        chk("stall_wait", issue_if.s_stall_from_lsu, 1);
        chk("req_wait", dmem_req, 0);
        tick();
        i_flush     = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
      end
    end
    exp_wb = ld && rd != 5'd0 && fl == 0;
    if (fl == 4) i_flush = 1'b1;
    #1;
    chk("stall_done", issue_if.s_stall_from_lsu, 0);
    chk("wb_en_done", wb_en, exp_wb);
    last_wb = wb_data;
    if (exp_wb) begin
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      chk("wb_data", wb_data, model_load(f3, ea, rdat));
    end
    tick();
    i_flush = 1'b0;
    chk("wb_en_idle", wb_en, 0);
  endtask

  initial begin
    bit          ld;
    int          f3, pick, fl;
    logic [31:0] base, imm, r;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    i_flush = 1'b0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    issue_if.m_valid = 1'b0;
    issue_if.m_uop = '0;
    issue_if.m_pc = '0;
    issue_if.m_addr_base = '0;
    issue_if.m_store_data = '0;
    repeat (3) tick();
    chk("rst_stall", issue_if.s_stall_from_lsu, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", {28'd0, dmem_be}, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 0);
    chk("rst_wb_data", wb_data, 0);
    rst_n = 1'b1;
    tick();

    run_op(1, 2, 5'd5, 32'h1000, 32'd8, 0, 0, 0, 32'hDEADBEEF, 0);
    chk("lw_const", last_wb, 32'hDEADBEEF);
    run_op(1, 0, 5'd7, 32'h2000, 32'd3, 0, 0, 0, 32'h80123456, 0);
    chk("lb_const", last_wb, 32'hFFFFFF80);
    run_op(1, 4, 5'd7, 32'h2000, 32'd3, 0, 0, 0, 32'h80123456, 0);
    chk("lbu_const", last_wb, 32'h00000080);
    run_op(0, 1, 5'd9, 32'h3000, 32'd2, 32'h0000ABCD, 3, 0, 0, 0);
    run_op(1, 2, 5'd3, 32'h4000, 32'd4, 0, 0, 2, 32'h12345678, 2);
    run_op(1, 2, 5'd0, 32'h5000, 32'd0, 0, 1, 0, 32'hCAFEF00D, 0);
    run_op(1, 1, 5'd4, 32'h6000, 32'd2, 0, 0, 1, 32'h8001FFFF, 1);
    run_op(0, 2, 5'd4, 32'h6000, 32'd4, 32'h55AA55AA, 2, 0, 0, 3);
    run_op(1, 5, 5'd6, 32'h7000, 32'd2, 0, 0, 0, 32'h9ABC0000, 4);

    set_uop(7'b0110011, 0, 5'd1, 32'h100, 32'd0, 0);
    #1;
    chk("unsup_stall", issue_if.s_stall_from_lsu, 0);
    tick();
    issue_if.m_valid = 1'b0;
    chk("unsup_req", dmem_req, 0);

    set_uop(OPC_LOAD, 2, 5'd8, 32'h8000, 32'd0, 0);
    tick();
    issue_if.m_valid = 1'b0;
    chk("rst_in_req_pre", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_req_req", dmem_req, 0);
    chk("rst_in_req_stall", issue_if.s_stall_from_lsu, 0);
    tick();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h11111111;
    tick();
    dmem_rvalid = 1'b0;
    chk("stray_rvalid_wb", wb_en, 0);
    chk("stray_rvalid_stall", issue_if.s_stall_from_lsu, 0);
    tick();
    chk("stray_rvalid_wb2", wb_en, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    set_uop(OPC_LOAD, 2, 5'd5, 32'h1000, 32'd1, 0);
    #1;
    chk("mis_stall", issue_if.s_stall_from_lsu, 1);
    tick();
    issue_if.m_valid = 1'b0;
    chk("mis_req", dmem_req, 0);
    chk("mis_pulse", misaligned, 1);
    chk("mis_addr", misaligned_addr, 32'h1001);
    chk("mis_wb", wb_en, 0);
    tick();
    chk("mis_pulse_end", misaligned, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1));
      if (ld) begin
        pick = int'($urandom_range(0, 4));
        f3 = (pick < 3) ? pick : pick + 1;
      end else begin
        f3 = int'($urandom_range(0, 2));
      end
      base = $urandom;
      r = $urandom;
      imm = {{20{r[11]}}, r[11:0]};
`ifdef LSU_MISALIGN_TRAP_EN
      base = base - ((base + imm) % nbytes(f3));
`endif
      fl = (n % 5 == 4) ? int'($urandom_range(1, 4)) : 0;
      run_op(ld, f3, 5'($urandom), base, imm, $urandom, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), $urandom, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
